// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, DR select and the TMS next-state arcs.
package jtag_pkg;

    // Encoding follows the conventional 1149.1 state numbering.
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BSR,
        DR_IDCODE,
        DR_BYPASS
    } dr_sel_t;

    localparam logic [3:0] OP_EXTEST = 4'b0000;
    localparam logic [3:0] OP_SAMPLE = 4'b0001;
    localparam logic [3:0] OP_IDCODE = 4'b0010;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TLR:      n = tms ? TLR      : RTI;
            RTI:      n = tms ? SEL_DR   : RTI;
            SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   n = tms ? EX1_DR   : SH_DR;
            SH_DR:    n = tms ? EX1_DR   : SH_DR;
            EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR   : SH_DR;
            UPD_DR:   n = tms ? SEL_DR   : RTI;
            SEL_IR:   n = tms ? TLR      : CAP_IR;
            CAP_IR:   n = tms ? EX1_IR   : SH_IR;
            SH_IR:    n = tms ? EX1_IR   : SH_IR;
            EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR   : SH_IR;
            UPD_IR:   n = tms ? SEL_DR   : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state register; advances on TCK rise, forced to Test-Logic-Reset by TRST.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= tap_next(state, TMS);
        end
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: IR, bypass/IDCODE registers, BSR strobes and TDO mux.
// Define JTAG_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h0A5AC0DF
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                TDO_oe,
    output logic                ShiftDR,
    output logic                ClockDR,
    output logic                UpdateDR,
    output logic                Mode,
    output logic [IR_WIDTH-1:0] ir_value
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = {IR_WIDTH{1'b1}};
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] RESET_OP  = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP  = IR_BYPASS;
`endif

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass;
    dr_sel_t             dr_sel;
    logic                dr_tdo;
    logic                bsr_sel;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir       <= RESET_OP;
            ir_shift <= '0;
            bypass   <= 1'b0;
        end else begin
            case (state)
                TLR:    ir       <= RESET_OP;
                CAP_IR: ir_shift <= IR_CAP;
                SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                UPD_IR: ir       <= ir_shift;
                CAP_DR: bypass   <= 1'b0;
                SH_DR:  if (dr_sel == DR_BYPASS) bypass <= TDI;
                default: ;
            endcase
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_sr;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (state == CAP_DR) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (state == SH_DR && dr_sel == DR_IDCODE) begin
            idcode_sr <= {TDI, idcode_sr[31:1]};
        end
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    // Undefined opcodes, and IDCODE when the register is absent, fall through to bypass.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == IR_EXTEST || ir == IR_SAMPLE) begin
            dr_sel = DR_BSR;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir == IR_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    always_comb begin
        dr_tdo = bypass;
        case (dr_sel)
            DR_BSR:    dr_tdo = bsr_tdo;
`ifdef JTAG_IDCODE_EN
            DR_IDCODE: dr_tdo = idcode_sr[0];
`endif
            default:   dr_tdo = bypass;
        endcase
    end

    always_comb begin
        TDO = 1'b0;
        if (state == SH_IR) begin
            TDO = ir_shift[0];
        end else if (state == SH_DR) begin
            TDO = dr_tdo;
        end
    end

    // Strobes decode straight from the registered state so each spans exactly its state's cycles.
    assign bsr_sel  = (dr_sel == DR_BSR);
    assign ClockDR  = bsr_sel && (state == CAP_DR || state == SH_DR);
    assign ShiftDR  = bsr_sel && (state == SH_DR);
    assign UpdateDR = bsr_sel && (state == UPD_DR);
    assign TDO_oe   = (state == SH_IR) || (state == SH_DR);
    assign Mode     = (ir == IR_EXTEST);
    assign ir_value = ir;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed-vector bench for jtag_tap_controller; follows JTAG_IDCODE_EN like the RTL.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_OP = 4'b0010;
`else
    localparam logic [3:0] RST_OP = 4'b1111;
`endif
    localparam logic [31:0] IDCODE = 32'h0A5AC0DF;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       bsr_tdo = 1'b0;
    logic       TDO, TDO_oe, ShiftDR, ClockDR, UpdateDR, Mode;
    logic [3:0] ir_value;

    int checks = 0;
    int errors = 0;

    jtag_tap_controller #(
        .IR_WIDTH     (4),
        .IDCODE_VALUE (IDCODE)
    ) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .TMS      (TMS),
        .TDI      (TDI),
        .bsr_tdo  (bsr_tdo),
        .TDO      (TDO),
        .TDO_oe   (TDO_oe),
        .ShiftDR  (ShiftDR),
        .ClockDR  (ClockDR),
        .UpdateDR (UpdateDR),
        .Mode     (Mode),
        .ir_value (ir_value)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic       tms, tdi, bsr;
        logic       tdo, oe, sh, ck, up, mode;
        logic [3:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic tms, input logic tdi, input logic bsr,
                       input logic tdo, input logic oe, input logic sh, input logic ck,
                       input logic up, input logic mode, input logic [3:0] ir);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.bsr = bsr;
        v.tdo = tdo; v.oe = oe; v.sh = sh; v.ck = ck; v.up = up; v.mode = mode; v.ir = ir;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; the caller checks outputs before calling.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
    endtask

    // From RTI: full IR scan of op (LSB first), returns to RTI with op active.
    task automatic ir_scan(input logic [3:0] op);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic goto_shdr();
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    logic [31:0] pat;
    logic        exp_bit;

    initial begin
        // IR scan 1111 and bypass DR shift, starting in TLR.
        add(0,0,0, 0,0,0,0,0,0, RST_OP);
        add(1,0,0, 0,0,0,0,0,0, RST_OP);
        add(1,0,0, 0,0,0,0,0,0, RST_OP);
        add(0,0,0, 0,0,0,0,0,0, RST_OP);
        add(0,0,0, 0,0,0,0,0,0, RST_OP);
        add(0,1,0, 1,1,0,0,0,0, RST_OP);
        add(0,1,0, 0,1,0,0,0,0, RST_OP);
        add(0,1,0, 0,1,0,0,0,0, RST_OP);
        add(1,1,0, 0,1,0,0,0,0, RST_OP);
        add(1,0,0, 0,0,0,0,0,0, RST_OP);
        add(0,0,0, 0,0,0,0,0,0, RST_OP);
        add(1,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,1, 0,0,0,0,0,0, 4'hF);
        add(0,1,1, 0,1,0,0,0,0, 4'hF);
        add(0,0,1, 1,1,0,0,0,0, 4'hF);
        add(0,1,0, 0,1,0,0,0,0, 4'hF);
        add(1,1,0, 1,1,0,0,0,0, 4'hF);
        add(1,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 0,0,0,0,0,0, 4'hF);
        // EXTEST load, then capture / 3 shifts / pause / update on the BSR.
        add(1,0,0, 0,0,0,0,0,0, 4'hF);
        add(1,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 1,1,0,0,0,0, 4'hF);
        add(0,0,0, 0,1,0,0,0,0, 4'hF);
        add(0,0,0, 0,1,0,0,0,0, 4'hF);
        add(1,0,0, 0,1,0,0,0,0, 4'hF);
        add(1,0,0, 0,0,0,0,0,0, 4'hF);
        add(0,0,0, 0,0,0,0,0,0, 4'hF);
        add(1,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,1, 0,0,0,1,0,1, 4'h0);
        add(0,0,1, 1,1,1,1,0,1, 4'h0);
        add(0,0,0, 0,1,1,1,0,1, 4'h0);
        add(1,0,1, 1,1,1,1,0,1, 4'h0);
        add(0,0,1, 0,0,0,0,0,1, 4'h0);
        add(1,0,1, 0,0,0,0,0,1, 4'h0);
        add(1,0,1, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 0,0,0,0,1,1, 4'h0);
        add(1,0,0, 0,0,0,0,0,1, 4'h0);
        // IR scan 0110 (undefined) -> bypass, no BSR strobes.
        add(1,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 1,1,0,0,0,1, 4'h0);
        add(0,1,0, 0,1,0,0,0,1, 4'h0);
        add(0,1,0, 0,1,0,0,0,1, 4'h0);
        add(1,0,0, 0,1,0,0,0,1, 4'h0);
        add(1,0,0, 0,0,0,0,0,1, 4'h0);
        add(0,0,0, 0,0,0,0,0,1, 4'h0);
        add(1,0,0, 0,0,0,0,0,0, 4'h6);
        add(0,0,0, 0,0,0,0,0,0, 4'h6);
        add(0,0,1, 0,0,0,0,0,0, 4'h6);
        add(0,1,1, 0,1,0,0,0,0, 4'h6);
        add(1,1,1, 1,1,0,0,0,0, 4'h6);
        add(1,0,1, 0,0,0,0,0,0, 4'h6);
        add(0,0,1, 0,0,0,0,0,0, 4'h6);

        // Reset state.
        repeat (2) @(negedge TCK);
        #1;
        check("rst_state", dut.u_fsm.state, TLR);
        check("rst_ir", ir_value, RST_OP);
        check("rst_outs", {TDO, TDO_oe, ShiftDR, ClockDR, UpdateDR, Mode}, 6'b0);
        TRST = 1'b0;
        @(negedge TCK);

        foreach (vecs[i]) begin
            TMS = vecs[i].tms;
            TDI = vecs[i].tdi;
            bsr_tdo = vecs[i].bsr;
            #1;
            check($sformatf("v%0d.tdo", i), TDO, vecs[i].tdo);
            check($sformatf("v%0d.oe", i), TDO_oe, vecs[i].oe);
            check($sformatf("v%0d.shift", i), ShiftDR, vecs[i].sh);
            check($sformatf("v%0d.clock", i), ClockDR, vecs[i].ck);
            check($sformatf("v%0d.update", i), UpdateDR, vecs[i].up);
            check($sformatf("v%0d.mode", i), Mode, vecs[i].mode);
            check($sformatf("v%0d.ir", i), ir_value, vecs[i].ir);
            @(posedge TCK);
            @(negedge TCK);
        end
        bsr_tdo = 1'b0;

        // TRST pulse in the middle of an EXTEST DR shift.
        ir_scan(4'b0000);
        goto_shdr();
        #1;
        check("pre_trst_shift", ShiftDR, 1'b1);
        TMS = 1'b1;
        TRST = 1'b1;
        #1;
        check("trst_state", dut.u_fsm.state, TLR);
        check("trst_ir", ir_value, RST_OP);
        check("trst_outs", {TDO_oe, ShiftDR, ClockDR, UpdateDR, Mode}, 5'b0);
        #1 TRST = 1'b0;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        check("post_trst_state", dut.u_fsm.state, TLR);
        check("post_trst_outs", {TDO_oe, ShiftDR, ClockDR, UpdateDR, Mode}, 5'b0);

        // 32 DR shifts straight after reset: IDCODE or a 1-bit bypass delay.
        pat = 32'h5A3C_96E1;
        step(0, 0);
        goto_shdr();
        for (int i = 0; i < 32; i++) begin
            TDI = pat[i];
            TMS = (i == 31);
            #1;
`ifdef JTAG_IDCODE_EN
            exp_bit = IDCODE[i];
`else
            exp_bit = (i == 0) ? 1'b0 : pat[i-1];
`endif
            check($sformatf("dr_bit%0d", i), TDO, exp_bit);
            @(posedge TCK);
            @(negedge TCK);
        end
        step(1, 0);
        step(0, 0);

        // Park in PauseIR holding a non-reset opcode, then TMS=1 x5 to TLR.
        ir_scan(4'b0001);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, 1'b0);
        step(0, 0);
        #1;
        check("pause_ir_state", dut.u_fsm.state, PAUSE_IR);
        check("pause_ir_hold", ir_value, 4'h1);
        check("pause_ir_oe", TDO_oe, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 0);
        #1;
        check("tms5_state", dut.u_fsm.state, TLR);
        check("tms5_mode_before", Mode, 1'b1);
        step(1, 0);
        #1;
        check("tlr_ir", ir_value, RST_OP);
        check("tlr_mode", Mode, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
